bist_ctrl_gen2: RTL and testbench
=================================

Name: bist_ctrl_gen2

Overview:
- Second-generation BIST sequencer: drives the pattern generator (LFSR) and signature register (MISR) of a block under test.
- Test length is run-time programmable: M_CFG rounds, each N_CFG active pattern cycles plus one reseed gap cycle.
- Adds an ABORT input and an on-chip signature compare with sticky PASS/FAIL.
- Sits between the top-level test access logic (START/ABORT) and the LFSR/MISR/CUT wrapper.

Parameters:
- N_W, 8, width of N_CFG and the pattern-cycle counter.
- M_W, 8, width of M_CFG and the round counter.
- SIG_W, 16, width of SIG_IN and GOLDEN.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- START  in  1  level request; a run starts on a 0->1 transition seen by the FSM
- ABORT  in  1  level; terminates a run in progress
- N_CFG  in  N_W  active pattern cycles per round (latched in INIT)
- M_CFG  in  M_W  number of rounds (latched in INIT)
- SIG_IN  in  SIG_W  MISR signature
- GOLDEN  in  SIG_W  expected signature (latched in INIT)
- INIT  out  1  one-cycle pulse; LFSR/MISR seed load
- RUNNING  out  1  high for every run cycle (active and gap)
- OUT  out  1  CUT pattern-enable; high on active cycles only
- SEED_LOAD  out  1  high on gap cycles; LFSR reseed
- ROUND  out  M_W  current round index
- FINISH  out  1  one-cycle pulse; signature compare cycle
- BIST_END  out  1  test complete
- PASS  out  1  sticky result
- FAIL  out  1  sticky result
- ABORTED  out  1  sticky abort flag

Behaviour:
- Reset is asynchronous and active-high on RESET; clock is CLK. On reset: state IDLE, counters and latched config zero, all outputs 0.
- Outputs are decoded from registered state and counters only; there is no combinational path from any input to any output.
- IDLE: leave for ARM when START=0. ARM: leave for INIT when START=1. A START held high through reset therefore never starts a run.
- INIT (1 cycle):
  - INIT=1.
  - Latch N_CFG, M_CFG and GOLDEN.
  - Clear n_cnt, m_cnt, PASS, FAIL and ABORTED.
  - Next state is RUN, or FINISH if M_CFG=0.
- RUN:
  - RUNNING=1 and ROUND=m_cnt on every cycle.
  - If n_cnt<N: OUT=1, n_cnt++.
  - If n_cnt==N (gap): OUT=0, SEED_LOAD=1, n_cnt<=0, m_cnt++. If m_cnt==M-1 on that gap, go to FINISH.
  - Each round is N+1 cycles; the run is M*(N+1) cycles with M*N OUT cycles.
  - N=0 gives gap-only rounds.
  - Counters never wrap within a run.
- FINISH (1 cycle):
  - FINISH=1, BIST_END=1.
  - Compare SIG_IN with the latched GOLDEN; register PASS=(equal), FAIL=!(equal).
  - Next state DONE.
- ABORT=1 in RUN: next state DONE, ABORTED<=1, FAIL<=1, PASS<=0. No FINISH pulse. ABORT is ignored in every other state.
- DONE: BIST_END=1; leave for REARM when START=0.
- REARM: BIST_END=1; leave for INIT when START=1.
- PASS, FAIL and ABORTED hold through DONE and REARM, and clear only in INIT or on reset.
- Config inputs may change at any time; only the INIT sample is used.
- RESET asserted mid-run returns the block to IDLE immediately. A full START 0->1 sequence is then required.
- Unused state encodings go to IDLE with all outputs 0.

Decomposition:
- Package bist_pkg holds:
  - the state enum (IDLE, ARM, INIT, RUN, FINISH, DONE, REARM);
  - default widths.
- Sub-module bist_round_counter holds the nested counter:
  - inputs: clear, enable, N, M;
  - outputs: n_cnt, m_cnt, gap, last.
- The FSM, config latch and compare live in bist_ctrl_gen2.

Test Plan:
- Reset with START=1, then release: block stays in IDLE/ARM, no INIT. Drop START, then raise it -> INIT pulse 2 cycles after the rising START.
- N_CFG=9, M_CFG=9, SIG_IN==GOLDEN:
  - RUNNING high for 90 consecutive cycles; OUT high 81 cycles; SEED_LOAD 9 pulses, every 10th cycle; ROUND steps 0..8.
  - Then one FINISH pulse, BIST_END=1, PASS=1, FAIL=0.
- Same run with SIG_IN=GOLDEN^16'h0001 -> FAIL=1, PASS=0, sticky until the next INIT.
- ABORT pulse at run cycle 20 -> RUNNING drops the next cycle; no FINISH; BIST_END=1, ABORTED=1, FAIL=1.
- Boundaries:
  - M_CFG=0 -> INIT then FINISH directly, RUNNING never high.
  - N_CFG=0, M_CFG=3 -> 3 RUN cycles, all SEED_LOAD, OUT never high.
- Back-to-back runs:
  - START held high after DONE -> no restart.
  - START low then high -> new INIT clears PASS/FAIL.
  - Change N_CFG mid-run -> run length unchanged.
  - RESET mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: state encoding and default widths shared by the BIST sequencer files.
package bist_pkg;
    localparam int N_W_DEF   = 8;
    localparam int M_W_DEF   = 8;
    localparam int SIG_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_INIT, S_RUN, S_FINISH, S_DONE, S_REARM
    } state_t;
endpackage

// File: rtl/bist_round_counter.sv
// bist_round_counter: nested pattern/round counter; each round is N active cycles plus one gap.
module bist_round_counter import bist_pkg::*; #(
    parameter int N_W = N_W_DEF,
    parameter int M_W = M_W_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           i_clear,
    input  logic           i_enable,
    input  logic [N_W-1:0] i_n,
    input  logic [M_W-1:0] i_m,
    output logic [N_W-1:0] o_n_cnt,
    output logic [M_W-1:0] o_m_cnt,
    output logic           o_gap,
    output logic           o_last
);
    logic [N_W-1:0] r_n_cnt;
    logic [M_W-1:0] r_m_cnt;

    assign o_n_cnt = r_n_cnt;
    assign o_m_cnt = r_m_cnt;
    assign o_gap   = r_n_cnt == i_n;
    assign o_last  = o_gap && (r_m_cnt == i_m - M_W'(1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_n_cnt <= '0;
            r_m_cnt <= '0;
        end else if (i_clear) begin
            r_n_cnt <= '0;
            r_m_cnt <= '0;
        end else if (i_enable) begin
            r_n_cnt <= o_gap ? '0 : r_n_cnt + N_W'(1);
            r_m_cnt <= o_gap ? r_m_cnt + M_W'(1) : r_m_cnt;
        end
    end
endmodule

// File: rtl/bist_ctrl_gen2.sv
// bist_ctrl_gen2: BIST sequencer with programmable length, abort and on-chip signature compare.
module bist_ctrl_gen2 import bist_pkg::*; #(
    parameter int N_W   = N_W_DEF,
    parameter int M_W   = M_W_DEF,
    parameter int SIG_W = SIG_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic [N_W-1:0]   N_CFG,
    input  logic [M_W-1:0]   M_CFG,
    input  logic [SIG_W-1:0] SIG_IN,
    input  logic [SIG_W-1:0] GOLDEN,
    output logic             INIT,
    output logic             RUNNING,
    output logic             OUT,
    output logic             SEED_LOAD,
    output logic [M_W-1:0]   ROUND,
    output logic             FINISH,
    output logic             BIST_END,
    output logic             PASS,
    output logic             FAIL,
    output logic             ABORTED
);
    state_t           r_state;
    logic             r_start;
    logic [N_W-1:0]   r_n;
    logic [M_W-1:0]   r_m;
    logic [SIG_W-1:0] r_golden;
    logic             r_pass;
    logic             r_fail;
    logic             r_aborted;
    logic [N_W-1:0]   w_n_cnt;
    logic [M_W-1:0]   w_m_cnt;
    logic             w_gap;
    logic             w_last;

    bist_round_counter #(.N_W(N_W), .M_W(M_W)) u_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_clear  (r_state == S_INIT),
        .i_enable (r_state == S_RUN),
        .i_n      (r_n),
        .i_m      (r_m),
        .o_n_cnt  (w_n_cnt),
        .o_m_cnt  (w_m_cnt),
        .o_gap    (w_gap),
        .o_last   (w_last)
    );

    assign INIT      = r_state == S_INIT;
    assign RUNNING   = r_state == S_RUN;
    assign OUT       = RUNNING && (w_n_cnt < r_n);
    assign SEED_LOAD = RUNNING && w_gap;
    assign ROUND     = RUNNING ? w_m_cnt : '0;
    assign FINISH    = r_state == S_FINISH;
    assign BIST_END  = FINISH || (r_state == S_DONE) || (r_state == S_REARM);
    assign PASS      = r_pass;
    assign FAIL      = r_fail;
    assign ABORTED   = r_aborted;

    // START is registered and resets high, so a START held through reset reads as already high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_start   <= 1'b1;
            r_n       <= '0;
            r_m       <= '0;
            r_golden  <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_start <= START;
            case (r_state)
                S_IDLE:   r_state <= r_start ? S_IDLE : S_ARM;
                S_ARM:    r_state <= r_start ? S_INIT : S_ARM;
                S_INIT: begin
                    r_n       <= N_CFG;
                    r_m       <= M_CFG;
                    r_golden  <= GOLDEN;
                    r_pass    <= 1'b0;
                    r_fail    <= 1'b0;
                    r_aborted <= 1'b0;
                    r_state   <= (M_CFG == '0) ? S_FINISH : S_RUN;
                end
                S_RUN: begin
                    if (ABORT) begin
                        r_state   <= S_DONE;
                        r_aborted <= 1'b1;
                        r_fail    <= 1'b1;
                        r_pass    <= 1'b0;
                    end else if (w_last) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_pass  <= SIG_IN == r_golden;
                    r_fail  <= SIG_IN != r_golden;
                    r_state <= S_DONE;
                end
                S_DONE:   r_state <= r_start ? S_DONE : S_REARM;
                S_REARM:  r_state <= r_start ? S_INIT : S_REARM;
                default:  r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bist_ctrl_gen2.sv
// tb_bist_ctrl_gen2: vector table plus randomized runs against an arithmetic round/pattern model.
module tb_bist_ctrl_gen2;
    logic        CLK = 1'b0;
    logic        RESET, START, ABORT;
    logic [7:0]  N_CFG, M_CFG, ROUND;
    logic [15:0] SIG_IN, GOLDEN;
    logic        INIT, RUNNING, OUT, SEED_LOAD, FINISH, BIST_END, PASS, FAIL, ABORTED;
    logic [16:0] w_outs;
    logic [2:0]  w_flags;
    logic [2:0]  prev_flags;
    int          checks = 0;
    int          failures = 0;

    bist_ctrl_gen2 dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .N_CFG(N_CFG), .M_CFG(M_CFG), .SIG_IN(SIG_IN), .GOLDEN(GOLDEN),
        .INIT(INIT), .RUNNING(RUNNING), .OUT(OUT), .SEED_LOAD(SEED_LOAD),
        .ROUND(ROUND), .FINISH(FINISH), .BIST_END(BIST_END),
        .PASS(PASS), .FAIL(FAIL), .ABORTED(ABORTED)
    );

    always #5 CLK = ~CLK;

    assign w_outs  = {INIT, RUNNING, OUT, SEED_LOAD, ROUND, FINISH, BIST_END, PASS, FAIL, ABORTED};
    assign w_flags = {PASS, FAIL, ABORTED};

    typedef struct {
        int          n;
        int          m;
        logic [15:0] g;
        logic [15:0] s;
        int          ab;
        int          e_len;
        int          e_out;
        int          e_seed;
        logic [2:0]  e_flags;
    } vec_t;

    vec_t tv[8];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete run from DONE/IDLE through to a held DONE; ab<0 means no abort.
    task automatic do_run(input int n, input int m, input logic [15:0] g, input logic [15:0] s,
                          input int ab, output int rl, output int oc, output int sc);
        int         len;
        bit         ab_hit;
        logic [2:0] ef;
        len    = m * (n + 1);
        ab_hit = (ab >= 0) && (ab < len);
        START = 1'b0;
        ABORT = 1'b0;
        repeat (3) tick();
        N_CFG  = 8'(n);
        M_CFG  = 8'(m);
        GOLDEN = g;
        SIG_IN = s;
        START  = 1'b1;
        tick();
        chk("init_early", INIT, 0);
        tick();
        chk("init_pulse", INIT, 1);
        chk("flags_held_to_init", w_flags, prev_flags);
        ABORT = 1'b1;
        tick();
        ABORT  = 1'b0;
        N_CFG  = 8'($urandom);
        M_CFG  = 8'($urandom);
        GOLDEN = 16'($urandom);
        chk("init_one_cycle", INIT, 0);
        chk("flags_cleared", w_flags, 0);
        rl = 0;
        oc = 0;
        sc = 0;
        for (int k = 0; k < (ab_hit ? ab + 1 : len); k++) begin
            chk("running", RUNNING, 1);
            chk("out", OUT, (k % (n + 1)) < n);
            chk("seed_load", SEED_LOAD, (k % (n + 1)) == n);
            chk("round", ROUND, k / (n + 1));
            chk("finish_in_run", FINISH | BIST_END, 0);
            rl += int'(RUNNING);
            oc += int'(OUT);
            sc += int'(SEED_LOAD);
            if (k == ab) ABORT = 1'b1;
            tick();
            ABORT = 1'b0;
        end
        chk("run_ended", RUNNING, 0);
        if (ab_hit) begin
            chk("abort_no_finish", FINISH, 0);
            chk("abort_end", BIST_END, 1);
            ef = 3'b011;
        end else begin
            chk("finish_pulse", FINISH, 1);
            chk("finish_end", BIST_END, 1);
            tick();
            chk("finish_one_cycle", FINISH, 0);
            ef = {s == g, s != g, 1'b0};
        end
        chk("result_flags", w_flags, ef);
        prev_flags = ef;
        for (int i = 0; i < 4; i++) begin
            ABORT = (i == 1);
            tick();
            chk("no_restart", INIT | RUNNING, 0);
            chk("done_end", BIST_END, 1);
            chk("flags_sticky", w_flags, ef);
        end
        ABORT = 1'b0;
    endtask

    initial begin
        int rl, oc, sc;
        int n, m, len, ab, e_out, e_seed;
        logic [15:0] g, s;
        tv[0] = '{9, 9, 16'hBEEF, 16'hBEEF, -1, 90, 81, 9, 3'b100};
        tv[1] = '{9, 9, 16'hBEEF, 16'hBEEE, -1, 90, 81, 9, 3'b010};
        tv[2] = '{9, 9, 16'h1234, 16'h1234, 20, 21, 19, 2, 3'b011};
        tv[3] = '{0, 3, 16'hA5A5, 16'hA5A5, -1, 3, 0, 3, 3'b100};
        tv[4] = '{5, 0, 16'h0F0F, 16'h0F0F, -1, 0, 0, 0, 3'b100};
        tv[5] = '{4, 2, 16'h7777, 16'h7777, -1, 10, 8, 2, 3'b100};
        tv[6] = '{255, 1, 16'h0001, 16'h8001, -1, 256, 255, 1, 3'b010};
        tv[7] = '{2, 2, 16'hCAFE, 16'hCAFE, 5, 6, 4, 2, 3'b011};

        prev_flags = 3'b000;
        RESET  = 1'b1;
        START  = 1'b1;
        ABORT  = 1'b0;
        N_CFG  = 8'd0;
        M_CFG  = 8'd0;
        SIG_IN = 16'd0;
        GOLDEN = 16'd0;
        repeat (3) tick();
        chk("reset_outs", w_outs, 0);
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_start_after_reset", INIT | RUNNING, 0);
        end

        foreach (tv[i]) begin
            do_run(tv[i].n, tv[i].m, tv[i].g, tv[i].s, tv[i].ab, rl, oc, sc);
            chk("vec_len", rl, tv[i].e_len);
            chk("vec_out", oc, tv[i].e_out);
            chk("vec_seed", sc, tv[i].e_seed);
            chk("vec_flags", w_flags, tv[i].e_flags);
        end

        for (int r = 0; r < 12; r++) begin
            n   = int'($urandom_range(0, 12));
            m   = int'($urandom_range(0, 6));
            g   = 16'($urandom);
            s   = ($urandom_range(0, 1) == 0) ? g : g ^ (16'h1 << $urandom_range(0, 15));
            len = m * (n + 1);
            ab  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            if (ab >= 0) len = ab + 1;
            e_out  = 0;
            e_seed = 0;
            for (int k = 0; k < len; k++) begin
                e_out  += ((k % (n + 1)) < n) ? 1 : 0;
                e_seed += ((k % (n + 1)) == n) ? 1 : 0;
            end
            do_run(n, m, g, s, ab, rl, oc, sc);
            chk("rnd_len", rl, len);
            chk("rnd_out", oc, e_out);
            chk("rnd_seed", sc, e_seed);
        end

        START = 1'b0;
        repeat (3) tick();
        N_CFG = 8'd9;
        M_CFG = 8'd9;
        START = 1'b1;
        repeat (3) tick();
        repeat (15) tick();
        chk("pre_reset_running", RUNNING, 1);
        #3 RESET = 1'b1;
        #1;
        chk("async_reset_outs", w_outs, 0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        prev_flags = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_start_after_midrun_reset", w_outs, 0);
        end
        do_run(3, 2, 16'h5A5A, 16'h5A5A, -1, rl, oc, sc);
        chk("post_reset_len", rl, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
